// File: rtl/apb_initiator_pkg.sv
// Shared types and defaults for the APB3 requester.
// FSM state encoding, default bus widths and the wait-counter sizing helper.
// Imported by apb_initiator; holds no logic of its own.
package apb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

  // Counter wide enough to hold TIMEOUT; a 1-bit stub when the timeout is disabled.
  function automatic int unsigned wait_cnt_w(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_initiator.sv
// APB3 requester: one valid/ready command in, one APB transfer out, one response pulse back.
// Latency: accept at edge N, SETUP cycle N+1, ACCESS N+2.., rsp_valid one cycle after PREADY.
// Backpressure: cmd_ready only in IDLE; responses are a one-cycle pulse with no backpressure.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [ADDR_W-1:0] m_paddr,
  output logic [DATA_W-1:0] m_pwdata,
  input  logic [DATA_W-1:0] m_prdata,
  input  logic              m_pready,
  input  logic              m_pslverr
);

  localparam int unsigned CNT_W = wait_cnt_w(TIMEOUT);
  // Count value seen on the last ACCESS cycle that is still allowed to wait.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (m_pready) begin
          // PREADY wins even on the last allowed wait cycle.
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = m_pslverr;
          rsp_rdata_d = (!pwrite_q && !m_pslverr) ? m_prdata : '0;
        end else if ((TIMEOUT != 0) && (cnt_q == LAST_WAIT)) begin
          // Slave never answered: abort the transfer and report an error.
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset drops any transfer silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: APB slave model with programmable wait states, error and read data.
// Expected responses are queued when a command is driven and compared when rsp_valid pulses.
module tb_apb_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // slave model configuration
  int          slave_waits     = 0;
  logic        slave_err       = 1'b0;
  logic [31:0] slave_rdata     = 32'h0;
  bit          slave_addr_mode = 1'b0;
  int          acc_cnt;

  // results of the last collect() call
  bit          r_got;
  logic        r_err;
  logic [31:0] r_rdata;
  int          r_lat;
  int          r_psel_n;
  int          r_pen_n;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;
  bit          r_unstable;

  apb_initiator #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // APB slave: answers on the ACCESS cycle numbered slave_waits (0 = no wait states).
  initial begin
    m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'hDEAD0000; acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (m_psel && m_penable) begin
        if (acc_cnt >= slave_waits) begin
          m_pready  = 1'b1;
          m_pslverr = slave_err;
          m_prdata  = slave_addr_mode ? {20'hA5A50, m_paddr} : slave_rdata;
        end else begin
          m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'hDEAD0000;
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0; m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'hDEAD0000;
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d, output bit ok);
    int n;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (cmd_ready) begin
      ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Watches the bus one cycle at a time until rsp_valid or the budget runs out.
  task automatic collect(input int budget);
    r_got = 0; r_err = 0; r_rdata = 0; r_lat = 0; r_psel_n = 0; r_pen_n = 0;
    r_addr = 0; r_wdata = 0; r_write = 0; r_unstable = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (m_psel) begin
        if (r_psel_n == 0) begin
          r_addr = m_paddr; r_wdata = m_pwdata; r_write = m_pwrite;
        end else if (m_paddr !== r_addr || m_pwdata !== r_wdata || m_pwrite !== r_write) begin
          r_unstable = 1;
        end
        r_psel_n++;
      end
      if (m_penable) r_pen_n++;
      if (rsp_valid) begin
        r_got = 1; r_lat = n; r_err = rsp_err; r_rdata = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'hFFF; cmd_wdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++;
    if ({m_psel, m_penable, m_pwrite, busy, rsp_valid, rsp_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {m_psel, m_penable, m_pwrite, busy, rsp_valid, rsp_err});
    end
    checks++;
    if (m_paddr !== 12'h0 || m_pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h expected zeros", m_paddr, m_pwdata, rsp_rdata);
    end
    cmd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_zero_wait();
    bit ok; exp_t e;
    slave_waits = 0; slave_err = 1'b0; slave_addr_mode = 1'b0; slave_rdata = 32'h77777777;
    e.err = 1'b0; e.rdata = 32'h0; sb_q.push_back(e);
    send_cmd(1'b1, 12'h00C, 32'h12345678, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_accept: got not accepted expected accepted"); end
    collect(20);
    checks++; if (r_got !== 1'b1) begin errors++; $display("FAIL wr_rsp: got no response expected response"); end
    checks++; if (r_lat != 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", r_lat); end
    checks++; if (r_psel_n != 2) begin errors++; $display("FAIL wr_psel_cycles: got %0d expected 2", r_psel_n); end
    checks++; if (r_pen_n != 1) begin errors++; $display("FAIL wr_penable_cycles: got %0d expected 1", r_pen_n); end
    checks++;
    if (r_addr !== 12'h00C || r_wdata !== 32'h12345678 || r_write !== 1'b1) begin
      errors++; $display("FAIL wr_bus: got addr=%h wdata=%h write=%b expected 00c 12345678 1", r_addr, r_wdata, r_write);
    end
    checks++; if (r_unstable) begin errors++; $display("FAIL wr_stable: got changing addr/data expected stable"); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (r_err !== e.err || r_rdata !== e.rdata) begin
        errors++; $display("FAIL wr_result: got err=%b rdata=%h expected err=%b rdata=%h", r_err, r_rdata, e.err, e.rdata);
      end
    end
    @(negedge clk);
    checks++;
    if (m_paddr !== 12'h00C || m_psel !== 1'b0) begin
      errors++; $display("FAIL wr_idle_hold: got paddr=%h psel=%b expected 00c 0", m_paddr, m_psel);
    end
  endtask

  task automatic test_read_wait();
    bit ok; exp_t e;
    slave_waits = 2; slave_err = 1'b0; slave_rdata = 32'hCAFEBABE;
    e.err = 1'b0; e.rdata = 32'hCAFEBABE; sb_q.push_back(e);
    send_cmd(1'b0, 12'h004, 32'h0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_accept: got not accepted expected accepted"); end
    collect(20);
    checks++; if (r_lat != 5) begin errors++; $display("FAIL rd_latency: got %0d expected 5", r_lat); end
    checks++; if (r_pen_n != 3) begin errors++; $display("FAIL rd_access_cycles: got %0d expected 3", r_pen_n); end
    checks++;
    if (r_addr !== 12'h004 || r_write !== 1'b0 || r_unstable) begin
      errors++; $display("FAIL rd_bus: got addr=%h write=%b unstable=%0d expected 004 0 0", r_addr, r_write, r_unstable);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (!r_got || r_err !== e.err || r_rdata !== e.rdata) begin
        errors++; $display("FAIL rd_result: got valid=%0d err=%b rdata=%h expected err=%b rdata=%h", r_got, r_err, r_rdata, e.err, e.rdata);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hCAFEBABE || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rd_hold: got valid=%b rdata=%h err=%b expected 0 cafebabe 0", rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_timeout();
    bit ok; exp_t e;
    slave_waits = 1000; slave_err = 1'b0; slave_rdata = 32'h11111111;
    e.err = 1'b1; e.rdata = 32'h0; sb_q.push_back(e);
    send_cmd(1'b0, 12'h040, 32'h0, ok);
    collect(60);
    checks++; if (r_pen_n != 16) begin errors++; $display("FAIL to_access_cycles: got %0d expected 16", r_pen_n); end
    checks++; if (r_lat != 18) begin errors++; $display("FAIL to_latency: got %0d expected 18", r_lat); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (!r_got || r_err !== e.err || r_rdata !== e.rdata) begin
        errors++; $display("FAIL to_result: got valid=%0d err=%b rdata=%h expected err=%b rdata=%h", r_got, r_err, r_rdata, e.err, e.rdata);
      end
    end
    checks++; if (m_psel !== 1'b0) begin errors++; $display("FAIL to_psel: got %b expected 0", m_psel); end
    slave_waits = 0;
    e.err = 1'b0; e.rdata = 32'h0; sb_q.push_back(e);
    send_cmd(1'b1, 12'h020, 32'hA0A0A0A0, ok);
    collect(20);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (!ok || !r_got || r_lat != 3 || r_err !== e.err) begin
        errors++; $display("FAIL to_next_cmd: got accepted=%0d valid=%0d lat=%0d err=%b expected 1 1 3 %b", ok, r_got, r_lat, r_err, e.err);
      end
    end
  endtask

  task automatic test_slverr();
    bit ok; exp_t e;
    logic        t_write [3] = '{1'b1, 1'b0, 1'b0};
    logic        t_err   [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] t_rd    [3] = '{32'h99999999, 32'h55AA55AA, 32'h600DF00D};
    slave_waits = 1;
    for (int i = 0; i < 3; i++) begin
      slave_err = t_err[i]; slave_rdata = t_rd[i];
      e.err = t_err[i];
      e.rdata = (!t_write[i] && !t_err[i]) ? t_rd[i] : 32'h0;
      sb_q.push_back(e);
      send_cmd(t_write[i], 12'h008 + 12'(4 * i), 32'h0BADC0DE, ok);
      collect(20);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (!r_got || r_err !== e.err || r_rdata !== e.rdata) begin
          errors++; $display("FAIL slverr_%0d: got valid=%0d err=%b rdata=%h expected err=%b rdata=%h", i, r_got, r_err, r_rdata, e.err, e.rdata);
        end
      end
    end
    slave_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_cyc [4];
    int rsp_cyc [4];
    int seen;
    int overlap;
    exp_t e;
    slave_waits = 0; slave_err = 1'b0; slave_addr_mode = 1'b1;
    seen = 0; overlap = 0;
    foreach (acc_cyc[i]) begin acc_cyc[i] = -100; rsp_cyc[i] = -200; end
    fork
      begin
        int n;
        exp_t d;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h100 + 12'(4 * i); cmd_wdata = 32'h0;
          d.err = 1'b0; d.rdata = {20'hA5A50, cmd_addr}; sb_q.push_back(d);
          n = 0;
          while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
          acc_cyc[i] = cyc;
          @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 60 && seen < 4; n++) begin
          @(negedge clk);
          if (m_psel && rsp_valid) overlap++;
          if (rsp_valid) begin
            rsp_cyc[seen] = cyc;
            checks++;
            if (sb_q.size() == 0) begin
              errors++; $display("FAIL b2b_unexpected_rsp: got response %0d expected none queued", seen);
            end else begin
              e = sb_q.pop_front();
              if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
                errors++; $display("FAIL b2b_rsp_%0d: got err=%b rdata=%h expected err=%b rdata=%h", seen, rsp_err, rsp_rdata, e.err, e.rdata);
              end
            end
            seen++;
          end
        end
      end
    join
    slave_addr_mode = 1'b0;
    checks++; if (seen != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", seen); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_overlap: got %0d expected 0", overlap); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_cyc[i+1] - acc_cyc[i] != 3) begin
        errors++; $display("FAIL b2b_accept_gap_%0d: got %0d expected 3", i, acc_cyc[i+1] - acc_cyc[i]);
      end
    end
    checks++;
    if (rsp_cyc[3] - acc_cyc[3] != 3) begin
      errors++; $display("FAIL b2b_last_latency: got %0d expected 3", rsp_cyc[3] - acc_cyc[3]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rv;
    slave_waits = 5;
    send_cmd(1'b0, 12'h030, 32'h0, ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_psel !== 1'b1 || m_penable !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_access: got psel=%b penable=%b expected 1 1", m_psel, m_penable);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_psel, m_penable, busy, rsp_valid, cmd_ready} !== 5'b0) begin
      errors++; $display("FAIL rstmid_abort: got psel/pen/busy/rv/ready=%b expected 00000", {m_psel, m_penable, busy, rsp_valid, cmd_ready});
    end
    rst = 1'b0;
    rv = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", cmd_ready); end
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) rv++;
      @(negedge clk);
    end
    checks++; if (rv != 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d responses expected 0", rv); end
    slave_waits = 0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0; cmd_wdata = 32'h0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
